control_unit: RTL

- Multi-cycle control FSM for the K&S 16-bit processor, paired one-to-one with the datapath.
- Consumes the datapath's decoded instruction and registered flags, and drives every datapath strobe plus the RAM write enable.
- Sequences fetch / decode / execute for all K&S instructions.
- Provides a halt indicator and a retired-instruction counter for the bench.

---
 rtl/control_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit -- multi-cycle control FSM for the K&S 16-bit processor.
//
// It works with the datapath. It takes the decoded instruction and the
// registered ALU flags, and it sequences fetch / decode / execute. Each
// datapath strobe and the RAM write enable come from a combinational decode
// of the state register.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 synchronous reset, active high (wins over everything)
//   decoded_instruction opcode class from the datapath's instruction decoder
//   zero_op, neg_op     registered flags used by conditional branches
//   unsigned_overflow,
//   signed_overflow     registered flags, observed only
//   branch              PC mux: 1 = instruction address, 0 = PC+1
//   pc_enable           PC load strobe
//   ir_enable           instruction register load strobe
//   addr_sel            RAM address mux: 1 = PC, 0 = instruction address
//   c_sel               write-back mux: 1 = data_in, 0 = ALU
//   operation           ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   write_reg_enable    register file write strobe
//   flags_reg_enable    flag register load strobe
//   ram_write_enable    RAM write strobe
//   halt                processor halted
//   instr_count         saturating retired-instruction counter
// ---------------------------------------------------------------------------

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [COUNT_W-1:0]      instr_count
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_LOAD_1,
    S_LOAD_2,
    S_STORE_1,
    S_STORE_2,
    S_MOVE,
    S_ALU,
    S_JUMP,
    S_BCOND,
    S_HALT
  } state_t;

  state_t                  state;
  state_t                  next_state;
  decoded_instruction_type opcode_q;
  logic                    retire;
  logic                    taken;
  logic [1:0]              alu_op;

  // The overflow flags come in only so the datapath can observe them. No
  // control decision uses them.
  logic unused_flags;
  assign unused_flags = unsigned_overflow ^ signed_overflow;

  // Next-state selection. Only DECODE looks at the live instruction input.
  // The execute states always go back to FETCH, and HALT stays in HALT
  // until reset.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:   next_state = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_NOP:                               next_state = S_FETCH;
          I_LOAD:                              next_state = S_LOAD_1;
          I_STORE:                             next_state = S_STORE_1;
          I_MOVE:                              next_state = S_MOVE;
          I_ADD, I_SUB, I_AND, I_OR:           next_state = S_ALU;
          I_BRANCH:                            next_state = S_JUMP;
          I_BZERO, I_BNZERO, I_BNEG, I_BNNEG:  next_state = S_BCOND;
          I_HALT:                              next_state = S_HALT;
          default:                             next_state = S_FETCH;
        endcase
      end
      S_LOAD_1:  next_state = S_LOAD_2;
      S_STORE_1: next_state = S_STORE_2;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_FETCH;
    endcase
  end

  // An instruction retires when it leaves DECODE or an execute state for
  // FETCH, or when it enters HALT. Because HALT is a self-loop and is left
  // out here, the counter freezes while the processor is halted.
  assign retire = (state != S_FETCH) && (state != S_HALT) &&
                  ((next_state == S_FETCH) || (next_state == S_HALT));

  // The state register, the opcode latch and the saturating retire counter.
  // The opcode is captured in DECODE so the execute states do not depend on
  // the datapath holding its decoder output stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      opcode_q    <= I_NOP;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        opcode_q <= decoded_instruction;
      end
      if (retire && (instr_count != {COUNT_W{1'b1}})) begin
        instr_count <= instr_count + COUNT_W'(1);
      end
    end
  end

  // The ALU operation and branch condition are computed from the latched
  // opcode. Both are only meaningful in their own execute states.
  always_comb begin
    alu_op = 2'b00;
    taken  = 1'b0;
    case (opcode_q)
      I_ADD:    alu_op = 2'b01;
      I_SUB:    alu_op = 2'b10;
      I_AND:    alu_op = 2'b11;
      I_BZERO:  taken  = zero_op;
      I_BNZERO: taken  = ~zero_op;
      I_BNEG:   taken  = neg_op;
      I_BNNEG:  taken  = ~neg_op;
      default: begin
        alu_op = 2'b00;
        taken  = 1'b0;
      end
    endcase
  end

  // Output decode of the state register. Every strobe defaults to 0. MOVE
  // uses OR because the datapath puts the same register on both ALU inputs.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      S_FETCH: begin
        addr_sel  = 1'b1;
        ir_enable = 1'b1;
      end
      S_DECODE:  pc_enable = 1'b1;
      S_LOAD_1:  c_sel = 1'b1;
      S_LOAD_2: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_STORE_2: ram_write_enable = 1'b1;
      S_MOVE:    write_reg_enable = 1'b1;
      S_ALU: begin
        operation        = alu_op;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
      end
      S_JUMP: begin
        branch    = 1'b1;
        pc_enable = 1'b1;
      end
      S_BCOND: begin
        branch    = taken;
        pc_enable = taken;
      end
      S_HALT:    halt = 1'b1;
      default:   halt = 1'b0;
    endcase
  end

endmodule
